// File: rtl/cab_slave_gen.sv
// CAB slave: serial header/data beats to single-word local register access, read data serialised back.
// Optional access timeout with error signalling when CAB_SLV_TIMEOUT_EN is defined.
module cab_slave_gen #(
    parameter int BUS_W   = 16,
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 14,
    parameter int TMO_CYC = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cab_xx_req_vld,
    input  logic [BUS_W-1:0]  cab_xx_req_data,
    output logic              xx_cab_ack_vld,
    output logic [BUS_W-1:0]  xx_cab_ack_data,
    output logic              xx_cab_err,
    output logic              xx_cab_rdy,
    output logic              cab_req,
    output logic              cab_wr,
    output logic [ADDR_W-1:0] cab_addr,
    output logic [DATA_W-1:0] cab_wdata,
    output logic              cab_ctrl,
    input  logic              cab_ack,
    input  logic [DATA_W-1:0] cab_rdata
);
    localparam int BEATS = DATA_W / BUS_W;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {IDLE, WR_DAT, WR_WAIT, RD_WAIT, RD_RSP} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                ctrl_q, ctrl_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                req_q, req_d;
    logic                wr_q, wr_d;
    logic                rdy_q, rdy_d;
    logic                ack_vld_q, ack_vld_d;
    logic [BUS_W-1:0]    ack_data_q, ack_data_d;
    logic                tmo_exp;

    logic                hdr_wr;
    logic                cnt_last;
    logic [CNT_W-1:0]    cnt_nxt;

    assign hdr_wr   = cab_xx_req_data[0];
    assign cnt_last = (cnt_q == CNT_W'(BEATS - 1));
    assign cnt_nxt  = cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            ctrl_q     <= 1'b0;
            wdata_q    <= '0;
            buf_q      <= '0;
            cnt_q      <= '0;
            req_q      <= 1'b0;
            wr_q       <= 1'b0;
            rdy_q      <= 1'b1;
            ack_vld_q  <= 1'b0;
            ack_data_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            ctrl_q     <= ctrl_d;
            wdata_q    <= wdata_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            req_q      <= req_d;
            wr_q       <= wr_d;
            rdy_q      <= rdy_d;
            ack_vld_q  <= ack_vld_d;
            ack_data_q <= ack_data_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (cab_xx_req_vld) state_d = hdr_wr ? WR_DAT : RD_WAIT;
            WR_DAT:  if (cab_xx_req_vld && cnt_last) state_d = WR_WAIT;
            WR_WAIT: if (cab_ack || tmo_exp) state_d = IDLE;
            RD_WAIT: if (cab_ack || tmo_exp) state_d = RD_RSP;
            RD_RSP:  if (cnt_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        addr_d     = addr_q;
        ctrl_d     = ctrl_q;
        wdata_d    = wdata_q;
        buf_d      = buf_q;
        cnt_d      = cnt_q;
        req_d      = req_q;
        wr_d       = wr_q;
        rdy_d      = rdy_q;
        ack_vld_d  = 1'b0;
        ack_data_d = '0;
        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                wr_d  = 1'b0;
                if (cab_xx_req_vld) begin
                    addr_d  = cab_xx_req_data[ADDR_W+1:2];
                    ctrl_d  = cab_xx_req_data[1];
                    wdata_d = '0;
                    cnt_d   = '0;
                    if (!hdr_wr) begin
                        req_d = 1'b1;
                        rdy_d = 1'b0;
                    end
                end
            end
            WR_DAT: begin
                if (cab_xx_req_vld) begin
                    wdata_d[cnt_q*BUS_W +: BUS_W] = cab_xx_req_data;
                    if (cnt_last) begin
                        cnt_d = '0;
                        req_d = 1'b1;
                        wr_d  = 1'b1;
                        rdy_d = 1'b0;
                    end else begin
                        cnt_d = cnt_nxt;
                    end
                end
            end
            WR_WAIT: begin
                if (cab_ack || tmo_exp) begin
                    req_d = 1'b0;
                    wr_d  = 1'b0;
                    rdy_d = 1'b1;
                end
            end
            RD_WAIT: begin
                // ack wins over a simultaneous timeout; an expired read answers all-ones
                if (cab_ack || tmo_exp) begin
                    buf_d      = cab_ack ? cab_rdata : '1;
                    req_d      = 1'b0;
                    cnt_d      = '0;
                    ack_vld_d  = 1'b1;
                    ack_data_d = cab_ack ? cab_rdata[BUS_W-1:0] : '1;
                end
            end
            RD_RSP: begin
                if (cnt_last) begin
                    cnt_d = '0;
                    rdy_d = 1'b1;
                end else begin
                    cnt_d      = cnt_nxt;
                    ack_vld_d  = 1'b1;
                    ack_data_d = buf_q[cnt_nxt*BUS_W +: BUS_W];
                end
            end
            default: begin
                req_d = 1'b0;
                wr_d  = 1'b0;
                rdy_d = 1'b1;
            end
        endcase
    end

`ifdef CAB_SLV_TIMEOUT_EN
    logic [15:0] tmo_q, tmo_d;
    logic        err_q, err_d;
    logic        rd_err_q, rd_err_d;

    assign tmo_exp = (state_q == WR_WAIT || state_q == RD_WAIT) && (tmo_q == 16'(TMO_CYC - 1));

    always_comb begin
        tmo_d    = '0;
        err_d    = 1'b0;
        rd_err_d = rd_err_q;
        case (state_q)
            WR_WAIT: begin
                if (!cab_ack) tmo_d = tmo_q + 16'd1;
                err_d = !cab_ack && tmo_exp;
            end
            RD_WAIT: begin
                if (!cab_ack) tmo_d = tmo_q + 16'd1;
                rd_err_d = !cab_ack && tmo_exp;
                err_d    = !cab_ack && tmo_exp;
            end
            RD_RSP: begin
                if (cnt_last) rd_err_d = 1'b0;
                else          err_d    = rd_err_q;
            end
            default: rd_err_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_q    <= '0;
            err_q    <= 1'b0;
            rd_err_q <= 1'b0;
        end else begin
            tmo_q    <= tmo_d;
            err_q    <= err_d;
            rd_err_q <= rd_err_d;
        end
    end

    assign xx_cab_err = err_q;
`else
    assign tmo_exp    = 1'b0;
    assign xx_cab_err = 1'b0;
`endif

    assign xx_cab_ack_vld  = ack_vld_q;
    assign xx_cab_ack_data = ack_data_q;
    assign xx_cab_rdy      = rdy_q;
    assign cab_req         = req_q;
    assign cab_wr          = wr_q;
    assign cab_addr        = addr_q;
    assign cab_wdata       = wdata_q;
    assign cab_ctrl        = ctrl_q;

endmodule

// File: tb/tb_cab_slave_gen.sv
// Directed bench for cab_slave_gen: default 16/32 instance, 16/64 instance and 32/32 instance.
module tb_cab_slave_gen;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // instance 0: BUS_W 16, DATA_W 32
    logic        vld0, ack0, ack_vld0, err0, rdy0, req0, wr0, ctrl0;
    logic [15:0] dat0, ack_dat0;
    logic [13:0] addr0;
    logic [31:0] wdata0, rdata0;
    // instance 1: BUS_W 16, DATA_W 64
    logic        vld1, ack1, ack_vld1, err1, rdy1, req1, wr1, ctrl1;
    logic [15:0] dat1, ack_dat1;
    logic [13:0] addr1;
    logic [63:0] wdata1, rdata1;
    // instance 2: BUS_W 32, DATA_W 32
    logic        vld2, ack2, ack_vld2, err2, rdy2, req2, wr2, ctrl2;
    logic [31:0] dat2, ack_dat2;
    logic [13:0] addr2;
    logic [31:0] wdata2, rdata2;

    cab_slave_gen #(.BUS_W(16), .DATA_W(32), .ADDR_W(14), .TMO_CYC(8)) u_d0 (
        .clk(clk), .rst(rst), .cab_xx_req_vld(vld0), .cab_xx_req_data(dat0),
        .xx_cab_ack_vld(ack_vld0), .xx_cab_ack_data(ack_dat0), .xx_cab_err(err0),
        .xx_cab_rdy(rdy0), .cab_req(req0), .cab_wr(wr0), .cab_addr(addr0),
        .cab_wdata(wdata0), .cab_ctrl(ctrl0), .cab_ack(ack0), .cab_rdata(rdata0));

    cab_slave_gen #(.BUS_W(16), .DATA_W(64), .ADDR_W(14)) u_d1 (
        .clk(clk), .rst(rst), .cab_xx_req_vld(vld1), .cab_xx_req_data(dat1),
        .xx_cab_ack_vld(ack_vld1), .xx_cab_ack_data(ack_dat1), .xx_cab_err(err1),
        .xx_cab_rdy(rdy1), .cab_req(req1), .cab_wr(wr1), .cab_addr(addr1),
        .cab_wdata(wdata1), .cab_ctrl(ctrl1), .cab_ack(ack1), .cab_rdata(rdata1));

    cab_slave_gen #(.BUS_W(32), .DATA_W(32), .ADDR_W(14)) u_d2 (
        .clk(clk), .rst(rst), .cab_xx_req_vld(vld2), .cab_xx_req_data(dat2),
        .xx_cab_ack_vld(ack_vld2), .xx_cab_ack_data(ack_dat2), .xx_cab_err(err2),
        .xx_cab_rdy(rdy2), .cab_req(req2), .cab_wr(wr2), .cab_addr(addr2),
        .cab_wdata(wdata2), .cab_ctrl(ctrl2), .cab_ack(ack2), .cab_rdata(rdata2));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        vld0 = 0; dat0 = '0; ack0 = 0; rdata0 = '0;
        vld1 = 0; dat1 = '0; ack1 = 0; rdata1 = '0;
        vld2 = 0; dat2 = '0; ack2 = 0; rdata2 = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_rdy0", rdy0, 1);
        chk("rst_req0", req0, 0);
        chk("rst_ackvld0", ack_vld0, 0);
        chk("rst_wdata0", wdata0, 0);
        chk("rst_addr0", addr0, 0);
        chk("rst_err0", err0, 0);
        chk("rst_rdy1", rdy1, 1);
        chk("rst_rdy2", rdy2, 1);

        // read, ack three cycles after cab_req rises
        vld0 = 1; dat0 = 16'h0012; tick(); vld0 = 0; dat0 = '0;
        chk("rd_req", req0, 1);
        chk("rd_wr", wr0, 0);
        chk("rd_rdy", rdy0, 0);
        chk("rd_addr", addr0, 14'h0004);
        chk("rd_ctrl", ctrl0, 1);
        tick(); chk("rd_req_c2", req0, 1);
        tick(); chk("rd_req_c3", req0, 1);
        ack0 = 1; rdata0 = 32'hCAFE_BEEF;
        tick(); ack0 = 0; rdata0 = '0;
        chk("rd_req_drop", req0, 0);
        chk("rd_b0_vld", ack_vld0, 1);
        chk("rd_b0", ack_dat0, 16'hBEEF);
        chk("rd_b0_rdy", rdy0, 0);
        chk("rd_b0_err", err0, 0);
        tick();
        chk("rd_b1_vld", ack_vld0, 1);
        chk("rd_b1", ack_dat0, 16'hCAFE);
        chk("rd_b1_rdy", rdy0, 0);
        tick();
        chk("rd_end_vld", ack_vld0, 0);
        chk("rd_end_dat", ack_dat0, 0);
        chk("rd_end_rdy", rdy0, 1);

        // write with a two-cycle gap between data beats
        vld0 = 1; dat0 = 16'h0009; tick(); dat0 = 16'h5678;
        chk("wr_hdr_addr", addr0, 14'h0002);
        chk("wr_hdr_ctrl", ctrl0, 0);
        chk("wr_hdr_req", req0, 0);
        chk("wr_hdr_rdy", rdy0, 1);
        tick(); vld0 = 0; dat0 = '0;
        tick(); tick();
        vld0 = 1; dat0 = 16'h1234; tick(); vld0 = 0; dat0 = '0;
        chk("wr_req", req0, 1);
        chk("wr_wr", wr0, 1);
        chk("wr_wdata", wdata0, 32'h1234_5678);
        chk("wr_rdy", rdy0, 0);
        tick(); tick();
        chk("wr_req_hold", req0, 1);
        chk("wr_wdata_hold", wdata0, 32'h1234_5678);
        chk("wr_no_beats", ack_vld0, 0);
        ack0 = 1; tick(); ack0 = 0;
        chk("wr_done_req", req0, 0);
        chk("wr_done_wr", wr0, 0);
        chk("wr_done_rdy", rdy0, 1);
        chk("wr_done_vld", ack_vld0, 0);

        // stray ack while idle
        ack0 = 1; rdata0 = 32'hFFFF_FFFF; tick(); ack0 = 0; rdata0 = '0;
        chk("stray_req", req0, 0);
        chk("stray_vld", ack_vld0, 0);
        chk("stray_rdy", rdy0, 1);

        // zero-wait read, then reset after the first beat
        vld0 = 1; dat0 = 16'h0020; tick(); vld0 = 0; dat0 = '0;
        chk("zw_addr", addr0, 14'h0008);
        ack0 = 1; rdata0 = 32'hA5A5_5A5A;
        tick(); ack0 = 0; rdata0 = '0;
        chk("zw_b0_vld", ack_vld0, 1);
        chk("zw_b0", ack_dat0, 16'h5A5A);
        rst = 1; tick(); rst = 0;
        chk("mrst_vld", ack_vld0, 0);
        chk("mrst_rdy", rdy0, 1);
        chk("mrst_req", req0, 0);
        tick();
        chk("mrst_no_beat", ack_vld0, 0);
        vld0 = 1; dat0 = 16'h0004; tick(); vld0 = 0; dat0 = '0;
        chk("post_addr", addr0, 14'h0001);
        chk("post_req", req0, 1);
        ack0 = 1; rdata0 = 32'h1111_2222;
        tick(); ack0 = 0; rdata0 = '0;
        chk("post_b0", ack_dat0, 16'h2222);
        tick(); chk("post_b1", ack_dat0, 16'h1111);
        tick(); chk("post_rdy", rdy0, 1);
        chk("post_vld", ack_vld0, 0);

        // 64-bit register over a 16-bit bus
        vld1 = 1; dat1 = 16'h0012; tick(); vld1 = 0; dat1 = '0;
        ack1 = 1; rdata1 = 64'h0123_4567_89AB_CDEF;
        tick(); ack1 = 0; rdata1 = '0;
        chk("w64_b0", ack_dat1, 16'hCDEF);
        tick(); chk("w64_b1", ack_dat1, 16'h89AB);
        tick(); chk("w64_b2", ack_dat1, 16'h4567);
        tick(); chk("w64_b3", ack_dat1, 16'h0123);
        chk("w64_b3_vld", ack_vld1, 1);
        chk("w64_b3_rdy", rdy1, 0);
        tick(); chk("w64_end_vld", ack_vld1, 0);
        chk("w64_end_rdy", rdy1, 1);

        // single-beat instance: write then read
        vld2 = 1; dat2 = 32'h0000_0009; tick(); dat2 = 32'hDEAD_BEEF;
        chk("b1_wr_hdr_req", req2, 0);
        tick(); vld2 = 0; dat2 = '0;
        chk("b1_wr_req", req2, 1);
        chk("b1_wr_wr", wr2, 1);
        chk("b1_wr_wdata", wdata2, 32'hDEAD_BEEF);
        chk("b1_wr_rdy", rdy2, 0);
        ack2 = 1; tick(); ack2 = 0;
        chk("b1_wr_done_req", req2, 0);
        chk("b1_wr_done_rdy", rdy2, 1);
        vld2 = 1; dat2 = 32'h0000_0012; tick(); vld2 = 0; dat2 = '0;
        ack2 = 1; rdata2 = 32'h7654_3210;
        tick(); ack2 = 0; rdata2 = '0;
        chk("b1_rd_vld", ack_vld2, 1);
        chk("b1_rd_dat", ack_dat2, 32'h7654_3210);
        chk("b1_rd_rdy", rdy2, 0);
        tick();
        chk("b1_rd_end_vld", ack_vld2, 0);
        chk("b1_rd_end_rdy", rdy2, 1);

`ifdef CAB_SLV_TIMEOUT_EN
        // read with no ack: eight cycles of cab_req, then all-ones beats with err
        vld0 = 1; dat0 = 16'h0012; tick(); vld0 = 0; dat0 = '0;
        for (int i = 0; i < 7; i++) begin
            chk("tmo_rd_req", req0, 1);
            tick();
        end
        chk("tmo_rd_req8", req0, 1);
        tick();
        chk("tmo_rd_drop", req0, 0);
        chk("tmo_rd_b0_vld", ack_vld0, 1);
        chk("tmo_rd_b0", ack_dat0, 16'hFFFF);
        chk("tmo_rd_b0_err", err0, 1);
        tick();
        chk("tmo_rd_b1", ack_dat0, 16'hFFFF);
        chk("tmo_rd_b1_err", err0, 1);
        tick();
        chk("tmo_rd_end_vld", ack_vld0, 0);
        chk("tmo_rd_end_err", err0, 0);
        chk("tmo_rd_end_rdy", rdy0, 1);

        // ack on the expiry cycle completes normally
        vld0 = 1; dat0 = 16'h0012; tick(); vld0 = 0; dat0 = '0;
        repeat (7) tick();
        ack0 = 1; rdata0 = 32'hCAFE_BEEF;
        tick(); ack0 = 0; rdata0 = '0;
        chk("tmo_ack_b0", ack_dat0, 16'hBEEF);
        chk("tmo_ack_b0_err", err0, 0);
        tick();
        chk("tmo_ack_b1", ack_dat0, 16'hCAFE);
        chk("tmo_ack_b1_err", err0, 0);
        tick();
        chk("tmo_ack_rdy", rdy0, 1);

        // write with no ack: one-cycle err pulse on return to idle
        vld0 = 1; dat0 = 16'h0009; tick();
        dat0 = 16'h5678; tick();
        dat0 = 16'h1234; tick(); vld0 = 0; dat0 = '0;
        repeat (7) tick();
        chk("tmo_wr_req8", req0, 1);
        tick();
        chk("tmo_wr_drop", req0, 0);
        chk("tmo_wr_err", err0, 1);
        chk("tmo_wr_rdy", rdy0, 1);
        tick();
        chk("tmo_wr_err_clr", err0, 0);
`else
        chk("err_tied0", err0, 0);
        chk("err_tied1", err1, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/cab_slave_gen.md
Name: cab_slave_gen

Overview:
- Parametrised CAB slave: converts serial CAB request beats (header plus data) into single-word local register accesses, and serialises read data back onto the CAB ack channel.
- Generalises bus width, register width and address width.
- Adds acknowledged writes (write request held until `cab_ack`) and optional access timeout with error signalling.
- Sits between the CAB ring and a block's local register file.

Parameters:
- BUS_W, 16, CAB beat width; must be ≥ ADDR_W+2.
- DATA_W, 32, local register data width; must be an integer multiple of BUS_W; BEATS = DATA_W/BUS_W, BEATS ≥ 1.
- ADDR_W, 14, local register address width.
- TMO_CYC, 255, cycles `cab_req` may wait for `cab_ack` before timeout (1..65535); used only with the optional feature.

Ports:
- clk, input, 1, clock.
- rst, input, 1, synchronous active-high reset.
- cab_xx_req_vld, input, 1, request beat valid.
- cab_xx_req_data, input, BUS_W, request beat.
- xx_cab_ack_vld, output, 1, response beat valid.
- xx_cab_ack_data, output, BUS_W, response beat.
- xx_cab_err, output, 1, access error flag.
- xx_cab_rdy, output, 1, slave ready for a new header.
- cab_req, output, 1, local access request, level.
- cab_wr, output, 1, 1 = write, 0 = read.
- cab_addr, output, ADDR_W, local address.
- cab_wdata, output, DATA_W, local write data.
- cab_ctrl, output, 1, control-space qualifier.
- cab_ack, input, 1, local access done.
- cab_rdata, input, DATA_W, local read data, valid with `cab_ack`.

Behaviour:
- **Clock and reset.** Single clock `clk`; reset `rst` is synchronous and active-high. Reset values:
  - state = IDLE
  - `xx_cab_rdy` = 1
  - all other outputs = 0, including the beat counter and timeout counter
- **Reset mid-operation.** Reset in any state aborts the access on the next edge: `cab_req` drops, no further beats are emitted, and the slave returns to IDLE.
- **Header decode.** Address = `cab_xx_req_data[ADDR_W+1:2]`; `ctrl` = bit 1; `wr` = bit 0.
- **States:** IDLE, WR_DAT, WR_WAIT, RD_WAIT, RD_RSP.
- **IDLE**
  - `cab_req` = 0, `cab_wr` = 0.
  - On `vld`: latch `addr` and `ctrl`, clear `cab_wdata` and the beat counter.
    - If `wr` = 1 → WR_DAT.
    - If `wr` = 0 → RD_WAIT: `cab_req` = 1, `cab_wr` = 0, `xx_cab_rdy` = 0 (all registered, visible the cycle after the header).
- **WR_DAT**
  - Each `vld` beat k (0..BEATS-1, least-significant first) is written into `cab_wdata[k*BUS_W +: BUS_W]`.
  - Accepting beat BEATS-1 → WR_WAIT, with `cab_req` = 1, `cab_wr` = 1, `xx_cab_rdy` = 0.
  - Gaps in `vld` are allowed.
- **WR_WAIT**
  - `cab_req`, `cab_wr`, `cab_addr` and `cab_wdata` are held stable.
  - On `cab_ack`: `cab_req` = 0, `cab_wr` = 0, `xx_cab_rdy` = 1 → IDLE.
  - No ack beats are sent for writes.
- **RD_WAIT**
  - On `cab_ack`: capture `cab_rdata` into the response buffer, `cab_req` = 0 → RD_RSP.
- **RD_RSP**
  - Beat k is output on cycles E+1..E+BEATS, where E is the ack edge: `xx_cab_ack_vld` = 1, `xx_cab_ack_data` = buffer slice k, least-significant first, back-to-back with no backpressure.
  - `xx_cab_rdy` returns to 1 in the cycle after the last beat → IDLE.
  - When not emitting, `xx_cab_ack_vld` = 0 and `xx_cab_ack_data` = 0.
- **Latency (read, zero-wait target).** Header sampled at edge T; `cab_req` high in cycle T+1; ack at edge T+1 gives the first beat in cycle T+2.
- **Boundary conditions**
  - `cab_xx_req_vld` is ignored while `xx_cab_rdy` = 0; the master must not send.
  - `cab_ack` outside WR_WAIT/RD_WAIT is ignored.
  - BEATS = 1: WR_DAT takes one beat; RD_RSP lasts one cycle.
  - Beat counter wraps to 0 on leaving WR_DAT/RD_RSP.
- `xx_cab_err` = 0 always, unless the optional feature is compiled in.

Optional Feature:
- Macro: CAB_SLV_TIMEOUT_EN.
- **With the macro:**
  - A 16-bit counter clears on entering WR_WAIT/RD_WAIT and increments each cycle `cab_req` = 1 without `cab_ack`.
  - When the count reaches TMO_CYC: `cab_req` drops.
    - Write → IDLE, with a one-cycle pulse `xx_cab_err` = 1 and `xx_cab_rdy` = 1.
    - Read → RD_RSP with an all-ones buffer; `xx_cab_err` = 1 on every response beat.
  - `cab_ack` on the same cycle as expiry wins: normal completion, no error.
- **Without the macro:** no counter; the slave waits indefinitely for `cab_ack`; `xx_cab_err` is tied to 0.

Test Plan:
- Defaults, read: header 0x0012 (addr 0x0004, ctrl 1, rd); `cab_ack` 3 cycles later with `rdata` 0xCAFE_BEEF → `cab_addr` = 0x0004, `cab_ctrl` = 1, `cab_req` high 3 cycles, then ack beats 0xBEEF, 0xCAFE on consecutive cycles; `rdy` low from header+1 until the cycle after the last beat.
- Defaults, write: header 0x0009, data beats 0x5678 then 0x1234 with a 2-cycle gap → `cab_wdata` = 0x1234_5678, `cab_wr` = 1, `cab_req` held until `cab_ack`, no ack beats.
- DATA_W=64, BUS_W=16, read `rdata` 0x0123_4567_89AB_CDEF → 4 beats: 0xCDEF, 0x89AB, 0x4567, 0x0123.
- BUS_W=DATA_W=32, write → single data beat; `cab_req` asserted the cycle after that beat.
- CAB_SLV_TIMEOUT_EN, TMO_CYC=8, read with no ack → `cab_req` drops after 8 cycles; beats 0xFFFF, 0xFFFF with `xx_cab_err` = 1. Repeat with ack on expiry cycle → normal data, `err` = 0.
- `rst` asserted in RD_RSP after the first beat → next cycle: `ack_vld` = 0, `rdy` = 1, IDLE; a subsequent read completes normally.
